decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 181 ++++++++++++++++++
 tb/tb_decode_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Single-issue instruction decode stage: output register plus 1-entry skid buffer.
// Optional performance counters are built only when DECODE_PERF_CNT_EN is defined.
module decode_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        aluop,
    output logic [4:0]        rd,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [DATA_W-1:0] imm,
    output logic [6:0]        ctrl,
    output logic [2:0]        br_cond,
    output logic [15:0]       perf_dec,
    output logic [15:0]       perf_bub
);

    typedef struct packed {
        logic [5:0]        aluop;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [DATA_W-1:0] imm;
        logic [6:0]        ctrl;
        logic [2:0]        br_cond;
    } bundle_t;

    bundle_t    dec;
    logic       is_stall;
    logic [6:0] op;
    logic       use_imm, reg_write, set_flags, mem_read, mem_write, branch, illegal;

    assign op = instr[31:25];

    always_comb begin
        use_imm   = 1'b0;
        reg_write = 1'b0;
        set_flags = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        illegal   = 1'b0;
        is_stall  = 1'b0;
        dec         = '0;
        dec.rd      = instr[24:20];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[14:10];
        dec.imm     = {{(DATA_W-15){instr[14]}}, instr[14:0]};
        if (op <= 7'h09) begin
            dec.aluop = 6'(op >> 1);
            use_imm   = op[0];
            reg_write = (op < 7'h08);
            set_flags = (op >= 7'h08);
        end else if (op == 7'h0A) begin
            dec.aluop = 6'd5;
            reg_write = 1'b1;
        end else if (op <= 7'h14) begin
            // odd opcode is the register form, even the immediate form
            dec.aluop = 6'd6 + 6'((op - 7'h0B) >> 1);
            use_imm   = ~op[0];
            reg_write = 1'b1;
        end else if (op == 7'h15 || op == 7'h16) begin
            dec.aluop = 6'd11;
            use_imm   = (op == 7'h16);
            reg_write = 1'b1;
        end else if (op == 7'h17) begin
            dec.aluop = 6'd12;
            use_imm   = 1'b1;
            mem_read  = 1'b1;
            reg_write = 1'b1;
        end else if (op == 7'h18) begin
            dec.aluop = 6'd13;
            use_imm   = 1'b1;
            mem_write = 1'b1;
        end else if (op <= 7'h26) begin
            dec.aluop   = op[0] ? 6'd14 : 6'd15;
            use_imm     = op[0];
            branch      = 1'b1;
            dec.br_cond = 3'((op - 7'h19) >> 1);
        end else if (op == 7'h7F) begin
            is_stall = 1'b1;
        end else begin
            illegal = 1'b1;
        end
        dec.ctrl = {use_imm, reg_write, set_flags, mem_read, mem_write, branch, illegal};
    end

    bundle_t out_q, out_d, skid_q, skid_d;
    logic    out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic    acc, acc_bundle, acc_stall, out_free;

    assign in_ready   = ~skid_valid_q;
    assign acc        = in_valid & in_ready & ~flush;
    assign acc_bundle = acc & ~is_stall;
    assign acc_stall  = acc & is_stall;
    assign out_free   = ~out_valid_q | out_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            // in_ready is low while the skid is full, so no new accept competes with the drain
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (acc_bundle) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (acc_bundle) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign aluop     = out_q.aluop;
    assign rd        = out_q.rd;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign imm       = out_q.imm;
    assign ctrl      = out_q.ctrl;
    assign br_cond   = out_q.br_cond;

`ifdef DECODE_PERF_CNT_EN
    logic [15:0] perf_dec_q, perf_dec_d, perf_bub_q, perf_bub_d;

    always_comb begin
        perf_dec_d = perf_dec_q + 16'(acc_bundle);
        perf_bub_d = perf_bub_q + 16'(acc_stall);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            perf_dec_q <= '0;
            perf_bub_q <= '0;
        end else begin
            perf_dec_q <= perf_dec_d;
            perf_bub_q <= perf_bub_d;
        end
    end

    assign perf_dec = perf_dec_q;
    assign perf_bub = perf_bub_q;
`else
    logic unused_stall;
    assign unused_stall = acc_stall;
    assign perf_dec     = '0;
    assign perf_bub     = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode table, skid buffering, stall, flush, reset.
module tb_decode_stage;

`ifdef DECODE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  aluop;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [6:0]  ctrl;
    logic [2:0]  br_cond;
    logic [15:0] perf_dec, perf_bub;

    int checks = 0;
    int fails  = 0;

    decode_stage #(.DATA_W(32)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .aluop(aluop),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .ctrl(ctrl), .br_cond(br_cond),
        .perf_dec(perf_dec), .perf_bub(perf_bub)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] r_d,
                                       input logic [4:0] r_s1, input logic [14:0] i15);
        return {op, r_d, r_s1, i15};
    endfunction

    task automatic test_reset();
        #3;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if ({aluop, rd, rs1, rs2, imm, ctrl, br_cond} !== '0) begin fails++; $display("FAIL reset_bundle got nonzero aluop=%0d ctrl=%b", aluop, ctrl); end
        checks++; if ({perf_dec, perf_bub} !== 32'h0) begin fails++; $display("FAIL reset_perf got %h/%h want 0", perf_dec, perf_bub); end
        @(negedge clk); nrst = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h02110005;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL addi_valid got %b want 1", out_valid); end
        checks++; if ({aluop, rd, rs1, imm, ctrl} !== {6'd0, 5'd1, 5'd2, 32'd5, 7'b1100000})
            begin fails++; $display("FAIL addi_fields got aluop=%0d rd=%0d rs1=%0d imm=%h ctrl=%b want 0/1/2/5/1100000", aluop, rd, rs1, imm, ctrl); end
        in_valid = 1'b1;
        instr    = mk(7'h01, 5'd8, 5'd2, 15'h7FFF);
        step();
        in_valid = 1'b0;
        checks++; if ({rd, rs1, rs2, imm} !== {5'd8, 5'd2, 5'd31, 32'hFFFFFFFF})
            begin fails++; $display("FAIL addi_neg got rd=%0d rs1=%0d rs2=%0d imm=%h want 8/2/31/ffffffff", rd, rs1, rs2, imm); end
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL addi_drain got %b want 0", out_valid); end
    endtask

    task automatic test_decode_table();
        logic [6:0] ops [12] = '{7'h03, 7'h08, 7'h0A, 7'h0C, 7'h13, 7'h16, 7'h17, 7'h18,
                                 7'h19, 7'h24, 7'h30, 7'h7E};
        logic [5:0] ealu [12] = '{6'd1, 6'd4, 6'd5, 6'd6, 6'd10, 6'd11, 6'd12, 6'd13,
                                  6'd14, 6'd15, 6'd0, 6'd0};
        logic [6:0] ectl [12] = '{7'b1100000, 7'b0010000, 7'b0100000, 7'b1100000, 7'b0100000,
                                  7'b1100000, 7'b1101000, 7'b1000100, 7'b1000010, 7'b0000010,
                                  7'b0000001, 7'b0000001};
        logic [2:0] ebc [12] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                                 3'd0, 3'd5, 3'd0, 3'd0};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            instr = mk(ops[i], 5'(i), 5'd0, 15'd0);
            step();
            checks++;
            if ({out_valid, aluop, ctrl, br_cond, rd} !== {1'b1, ealu[i], ectl[i], ebc[i], 5'(i)})
                begin fails++; $display("FAIL dec_op%h got v=%b alu=%0d ctrl=%b bc=%0d rd=%0d want 1/%0d/%b/%0d/%0d",
                    ops[i], out_valid, aluop, ctrl, br_cond, rd, ealu[i], ectl[i], ebc[i], i); end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = mk(7'h24, 5'd0, 5'd3, 15'd0);
        step();
        checks++; if ({aluop, br_cond, ctrl} !== {6'd15, 3'd5, 7'b0000010})
            begin fails++; $display("FAIL brlt got alu=%0d bc=%0d ctrl=%b want 15/5/0000010", aluop, br_cond, ctrl); end
        instr = mk(7'h21, 5'd0, 5'd3, 15'h0040);
        step();
        in_valid = 1'b0;
        checks++; if ({out_valid, aluop, br_cond, ctrl, imm} !== {1'b1, 6'd14, 3'd4, 7'b1000010, 32'h40})
            begin fails++; $display("FAIL bge got v=%b alu=%0d bc=%0d ctrl=%b imm=%h want 1/14/4/1000010/40", out_valid, aluop, br_cond, ctrl, imm); end
        step();
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = mk(7'h00, 5'd1, 5'd0, 15'd0);
        step();
        instr = mk(7'h00, 5'd2, 5'd0, 15'd0);
        step();
        instr = mk(7'h00, 5'd3, 5'd0, 15'd0);
        checks++; if ({out_valid, rd, in_ready} !== {1'b1, 5'd1, 1'b0})
            begin fails++; $display("FAIL skid_full got v=%b rd=%0d rdy=%b want 1/1/0", out_valid, rd, in_ready); end
        step();
        checks++; if ({out_valid, rd, in_ready} !== {1'b1, 5'd1, 1'b0})
            begin fails++; $display("FAIL skid_hold got v=%b rd=%0d rdy=%b want 1/1/0", out_valid, rd, in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if ({out_valid, rd, in_ready} !== {1'b1, 5'd2, 1'b1})
            begin fails++; $display("FAIL skid_drain got v=%b rd=%0d rdy=%b want 1/2/1", out_valid, rd, in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if ({out_valid, rd} !== {1'b1, 5'd3})
            begin fails++; $display("FAIL skid_third got v=%b rd=%0d want 1/3", out_valid, rd); end
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL skid_empty got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        int n = 0;
        nrst = 1'b0; #2; nrst = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr = mk(7'h00, 5'd4, 5'd0, 15'd0);
        step(); n += int'(out_valid);
        instr = {7'h7F, 25'd0};
        step(); n += int'(out_valid);
        instr = mk(7'h00, 5'd5, 5'd0, 15'd0);
        step(); n += int'(out_valid);
        checks++; if (rd !== 5'd5) begin fails++; $display("FAIL stall_order got rd=%0d want 5", rd); end
        in_valid = 1'b0;
        step(); n += int'(out_valid);
        checks++; if (n !== 2) begin fails++; $display("FAIL stall_count got %0d bundles want 2", n); end
        checks++; if ({perf_dec, perf_bub} !== (PERF ? {16'd2, 16'd1} : 32'd0))
            begin fails++; $display("FAIL stall_perf got dec=%0d bub=%0d", perf_dec, perf_bub); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr = mk(7'h00, 5'd6, 5'd0, 15'd0);
        step();
        instr = mk(7'h00, 5'd7, 5'd0, 15'd0);
        step();
        instr = mk(7'h00, 5'd8, 5'd0, 15'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01)
            begin fails++; $display("FAIL flush_state got v=%b rdy=%b want 0/1", out_valid, in_ready); end
        checks++; if ({perf_dec, perf_bub} !== (PERF ? {16'd4, 16'd1} : 32'd0))
            begin fails++; $display("FAIL flush_perf got dec=%0d bub=%0d", perf_dec, perf_bub); end
        in_valid = 1'b1;
        instr = mk(7'h17, 5'd9, 5'd1, 15'h1234);
        step();
        in_valid = 1'b0;
        checks++; if ({out_valid, aluop, rd} !== {1'b1, 6'd12, 5'd9})
            begin fails++; $display("FAIL flush_resume got v=%b alu=%0d rd=%0d want 1/12/9", out_valid, aluop, rd); end
        nrst = 1'b0;
        #1;
        checks++; if ({out_valid, aluop, rd, rs1, rs2, imm, ctrl, br_cond, perf_dec, perf_bub} !== '0)
            begin fails++; $display("FAIL midreset got v=%b alu=%0d rd=%0d imm=%h ctrl=%b", out_valid, aluop, rd, imm, ctrl); end
        @(negedge clk); nrst = 1'b1;
        step();
        checks++; if ({in_ready, out_valid} !== 2'b10)
            begin fails++; $display("FAIL midreset_rel got rdy=%b v=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = mk(7'h00, 5'd1, 5'd1, 15'd1);
        for (int i = 0; i < 65535; i++) step();
        checks++; if (perf_dec !== (PERF ? 16'hFFFF : 16'h0))
            begin fails++; $display("FAIL wrap_max got %h", perf_dec); end
        step();
        in_valid = 1'b0;
        checks++; if ({perf_dec, perf_bub} !== 32'h0)
            begin fails++; $display("FAIL wrap_zero got dec=%h bub=%h want 0/0", perf_dec, perf_bub); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_decode_table();
        test_branch();
        test_skid();
        test_stall();
        test_flush();
        test_wrap();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
